// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
// Shared types and sizing helpers for the pipeline stall/flush controller.
//   ctrl_state_t   : controller FSM states (RUN, MEM_WAIT, HALT)
//   CNT_W_DEFAULT  : default performance-counter width
//   wait_cnt_w()   : width of the memory-wait counter for a given timeout
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } ctrl_state_t;

  localparam int CNT_W_DEFAULT   = 16;
  localparam int MEM_TIMEOUT_MAX = 255;
  // Widest wait counter any legal timeout can need.
  localparam int WAIT_W_MAX      = $clog2(MEM_TIMEOUT_MAX + 1);

  // wait_cnt must be able to hold MEM_TIMEOUT itself.
  function automatic int wait_cnt_w(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// pipeline_stall_controller_if
// Hazard/memory status flowing into the stall controller and the pipeline
// register enables / flush strobes flowing back to the datapath.
//   master : datapath side (drives hazard + memory status, receives enables)
//   slave  : controller side
interface pipeline_stall_controller_if;
  logic load_use;
  logic branch_taken;
  logic mem_req;
  logic mem_ack;
  logic pc_write;
  logic ifid_write;
  logic ctrl_zero;
  logic pipe_hold;
  logic flush_ifid;
  logic flush_idex;
  logic flush_exmem;

  modport master (
    output load_use, branch_taken, mem_req, mem_ack,
    input  pc_write, ifid_write, ctrl_zero, pipe_hold,
           flush_ifid, flush_idex, flush_exmem
  );

  modport slave (
    input  load_use, branch_taken, mem_req, mem_ack,
    output pc_write, ifid_write, ctrl_zero, pipe_hold,
           flush_ifid, flush_idex, flush_exmem
  );
endinterface

// File: rtl/sat_counter.sv
// sat_counter
// Up counter that sticks at all-ones instead of wrapping.
//   clk   : clock
//   reset : synchronous active-high clear
//   inc   : count this cycle
//   count : current value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller
// Merges load-use stalls, taken-branch flushes and the data-memory handshake
// into pipeline register enables, flush strobes and the bubble select.
// All outputs are Mealy: a stall, flush or release acts in the cycle of its cause.
//   clk, reset     : clock, synchronous active-high reset
//   bus (slave)    : hazard/memory inputs, pipeline control outputs
//   proto_err      : sticky, mem_req and branch_taken seen together in RUN
//   halted         : sticky, memory watchdog expired
//   stall_cycles   : saturating count of stalled (pc_write=0) cycles
//   flush_count    : saturating count of taken-branch flushes
module pipeline_stall_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = CNT_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_stall_controller_if.slave bus,
  output logic                 proto_err,
  output logic                 halted,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     flush_count
);

  localparam int WAIT_W = wait_cnt_w(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

  ctrl_state_t       state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              miss;
  logic              timeout;
  logic              pc_write, ifid_write, ctrl_zero, pipe_hold;
  logic              flush_all;
  logic              stall_inc;

  assign miss    = bus.mem_req & ~bus.mem_ack;
  assign timeout = (state == MEM_WAIT) && !bus.mem_ack && (wait_cnt == TIMEOUT_V);

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:      if (miss) state_nxt = MEM_WAIT;
      MEM_WAIT: begin
        if (bus.mem_ack)  state_nxt = RUN;
        else if (timeout) state_nxt = HALT;
      end
      HALT:     state_nxt = HALT;
      default:  state_nxt = RUN;
    endcase
  end

  // Priority in RUN: memory miss, then branch flush, then load-use.
  // A branch alongside a memory access is a protocol error and is dropped.
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ctrl_zero  = 1'b0;
    pipe_hold  = 1'b0;
    flush_all  = 1'b0;
    if (reset) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ctrl_zero  = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (miss) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
          end else if (bus.branch_taken && !bus.mem_req) begin
            flush_all  = 1'b1;
          end else if (bus.load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ctrl_zero  = 1'b1;
          end
        end
        MEM_WAIT: begin
          // The ack cycle itself lets the pipeline advance.
          if (!bus.mem_ack) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
          end
        end
        default: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          pipe_hold  = 1'b1;
          ctrl_zero  = 1'b1;
        end
      endcase
    end
  end

  assign bus.pc_write    = pc_write;
  assign bus.ifid_write  = ifid_write;
  assign bus.ctrl_zero   = ctrl_zero;
  assign bus.pipe_hold   = pipe_hold;
  assign bus.flush_ifid  = flush_all;
  assign bus.flush_idex  = flush_all;
  assign bus.flush_exmem = flush_all;

  // wait_cnt numbers the MEM_WAIT cycle in progress (1 on the first one).
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if ((state == RUN) && miss) begin
      wait_cnt <= WAIT_W'(1);
    end else if ((state == MEM_WAIT) && !bus.mem_ack && (wait_cnt != TIMEOUT_V)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      proto_err <= 1'b0;
      halted    <= 1'b0;
    end else begin
      if ((state == RUN) && bus.mem_req && bus.branch_taken) proto_err <= 1'b1;
      if (timeout) halted <= 1'b1;
    end
  end

  assign stall_inc = !reset && (state != HALT) && !pc_write;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_all),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb_pipeline_stall_controller
// Table-driven directed vectors, hand-written watchdog/reset corner sequences,
// randomized stimulus against a behavioural model, and counter saturation.
module tb_pipeline_stall_controller;

  localparam int TO   = 4;
  localparam int CW   = 16;
  localparam int SMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          proto_err, halted;
  logic [CW-1:0] stall_cycles, flush_count;

  int n_vec = 0;
  int n_err = 0;

  pipeline_stall_controller_if bus();

  pipeline_stall_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .proto_err    (proto_err),
    .halted       (halted),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  always #5 clk = ~clk;

  // {pc_write, ifid_write, ctrl_zero, pipe_hold, flush_ifid, flush_idex, flush_exmem}
  localparam logic [6:0] NORM = 7'b1100000;
  localparam logic [6:0] RSTO = 7'b0010000;
  localparam logic [6:0] LUS  = 7'b0010000;
  localparam logic [6:0] MWT  = 7'b0001000;
  localparam logic [6:0] FLU  = 7'b1100111;
  localparam logic [6:0] HLT  = 7'b0011000;

  typedef struct {
    logic       rst, lu, br, mr, ma;
    logic [6:0] ctl;
    bit         chk;
    int         stall, flush;
    logic       proto, halt;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model state
  bit m_waiting;
  int m_waited;
  bit m_halted;
  bit m_proto;
  int m_stall;
  int m_flush;

  function automatic logic [6:0] act_ctl();
    return {bus.pc_write, bus.ifid_write, bus.ctrl_zero, bus.pipe_hold,
            bus.flush_ifid, bus.flush_idex, bus.flush_exmem};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, lu, br, mr, ma, input logic [6:0] ctl,
                     input bit chk_c, input int stall, flush, input logic proto, halt);
    vec_t v;
    v.rst = rst; v.lu = lu; v.br = br; v.mr = mr; v.ma = ma; v.ctl = ctl;
    v.chk = chk_c; v.stall = stall; v.flush = flush; v.proto = proto; v.halt = halt;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic rst, lu, br, mr, ma);
    reset = rst;
    bus.load_use = lu;
    bus.branch_taken = br;
    bus.mem_req = mr;
    bus.mem_ack = ma;
  endtask

  function automatic int sat_inc(input int x);
    return (x >= SMAX) ? SMAX : x + 1;
  endfunction

  // Expected controls from the rules: reset, halt, waiting on memory, then
  // RUN priority miss > branch > load-use > normal.
  function automatic logic [6:0] model_out(input logic rst, lu, br, mr, ma);
    if (rst)                return RSTO;
    if (m_halted)           return HLT;
    if (m_waiting)          return ma ? NORM : MWT;
    if (mr && !ma)          return MWT;
    if (br && !mr)          return FLU;
    if (lu)                 return LUS;
    return NORM;
  endfunction

  task automatic model_update(input logic rst, lu, br, mr, ma);
    if (rst) begin
      m_waiting = 0; m_waited = 0; m_halted = 0; m_proto = 0;
      m_stall = 0; m_flush = 0;
    end else if (m_halted) begin
      // frozen until reset
    end else if (m_waiting) begin
      if (ma) begin
        m_waiting = 0;
      end else begin
        m_stall = sat_inc(m_stall);
        if (m_waited + 1 == TO) begin
          m_halted  = 1;
          m_waiting = 0;
        end else begin
          m_waited++;
        end
      end
    end else begin
      if (mr && br) m_proto = 1;
      if (mr && !ma) begin
        m_stall = sat_inc(m_stall);
        m_waiting = 1;
        m_waited  = 0;
      end else if (br && !mr) begin
        m_flush = sat_inc(m_flush);
      end else if (lu) begin
        m_stall = sat_inc(m_stall);
      end
    end
  endtask

  task automatic step(input logic rst, lu, br, mr, ma);
    logic [6:0] e;
    drive(rst, lu, br, mr, ma);
    e = model_out(rst, lu, br, mr, ma);
    @(negedge clk);
    chk("ctl", 32'(act_ctl()), 32'(e));
    chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
    chk("flush_count", 32'(flush_count), 32'(m_flush));
    chk("proto_err", 32'(proto_err), 32'(m_proto));
    chk("halted", 32'(halted), 32'(m_halted));
    @(posedge clk);
    model_update(rst, lu, br, mr, ma);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    //   rst lu br mr ma  ctl   chk stall flush proto halt
    add(1, 0, 0, 0, 0, RSTO, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, RSTO, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, NORM, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, LUS,  1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, LUS,  1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, NORM, 1, 2, 0, 0, 0);
    add(0, 0, 0, 1, 0, MWT,  1, 2, 0, 0, 0);   // miss
    add(0, 0, 0, 1, 0, MWT,  1, 3, 0, 0, 0);
    add(0, 0, 0, 1, 0, MWT,  1, 4, 0, 0, 0);
    add(0, 0, 0, 1, 1, NORM, 1, 5, 0, 0, 0);   // ack releases in same cycle
    add(0, 0, 0, 0, 0, NORM, 1, 5, 0, 0, 0);
    add(0, 1, 1, 0, 0, FLU,  1, 5, 0, 0, 0);   // branch beats load-use
    add(0, 0, 0, 0, 0, NORM, 1, 5, 1, 0, 0);
    add(0, 0, 1, 1, 1, NORM, 1, 5, 1, 0, 0);   // proto error, branch dropped
    add(0, 0, 0, 0, 0, NORM, 1, 5, 1, 1, 0);
    add(0, 1, 0, 1, 1, LUS,  1, 5, 1, 1, 0);   // single-cycle memory + load-use
    add(0, 0, 0, 0, 0, NORM, 1, 6, 1, 1, 0);
    add(0, 0, 0, 1, 0, MWT,  1, 6, 1, 1, 0);   // miss, never acked
    add(0, 1, 1, 1, 0, MWT,  1, 7, 1, 1, 0);
    add(0, 1, 1, 1, 0, MWT,  1, 8, 1, 1, 0);
    add(0, 1, 1, 1, 0, MWT,  1, 9, 1, 1, 0);
    add(0, 1, 1, 1, 0, MWT,  1, 10, 1, 1, 0);
    add(0, 0, 0, 0, 1, HLT,  1, 11, 1, 1, 1);
    add(0, 0, 1, 0, 0, HLT,  1, 11, 1, 1, 1);
    add(1, 0, 0, 0, 0, RSTO, 1, 11, 1, 1, 1);
    add(0, 0, 0, 0, 0, NORM, 1, 0, 0, 0, 0);

    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].lu, tbl[i].br, tbl[i].mr, tbl[i].ma);
      @(negedge clk);
      chk($sformatf("tbl_ctl[%0d]", i), 32'(act_ctl()), 32'(tbl[i].ctl));
      if (tbl[i].chk) begin
        chk($sformatf("tbl_stall[%0d]", i), 32'(stall_cycles), 32'(tbl[i].stall));
        chk($sformatf("tbl_flush[%0d]", i), 32'(flush_count), 32'(tbl[i].flush));
        chk($sformatf("tbl_proto[%0d]", i), 32'(proto_err), 32'(tbl[i].proto));
        chk($sformatf("tbl_halt[%0d]", i), 32'(halted), 32'(tbl[i].halt));
      end
      @(posedge clk);
      #1;
    end

    // ack arriving on the final watchdog cycle wins
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < TO - 1; i++) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    chk("ack_wins_halted", 32'(halted), 32'(0));
    step(0, 0, 0, 0, 0);

    // reset in MEM_WAIT returns to RUN regardless of mem_ack
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0);
    #1;
    chk("rst_mw_pc_write", 32'(bus.pc_write), 32'(1));
    step(0, 0, 0, 0, 0);

    // randomized against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 1) == 0));
    end

    // stall counter saturation
    step(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < SMAX + 5; i++) @(posedge clk);
    #1;
    chk("stall_sat", 32'(stall_cycles), 32'(SMAX));
    repeat (3) @(posedge clk);
    #1;
    chk("stall_sat_hold", 32'(stall_cycles), 32'(SMAX));
    chk("stall_sat_pc_write", 32'(bus.pc_write), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
